// File: rtl/hilo_pkg.sv
// hilo_pkg: shared types and constants for the HI/LO multiply sequencer.
//   DATA_W   : architectural word width
//   CNT_W    : width of the RUN-phase cycle counter
//   MULT_LAT : RUN cycles before mult_done can be trusted
//   TIMEOUT  : last RUN count before the operation is abandoned
package hilo_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned CNT_W    = 6;
   localparam int unsigned MULT_LAT = 34;
   localparam int unsigned TIMEOUT  = 63;

   typedef logic [DATA_W-1:0] word_t;

   // Sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CLR  = 2'd1,
      RUN  = 2'd2,
      CAPT = 2'd3
   } state_e;

   // Architectural HI/LO register pair
   typedef struct packed {
      word_t hi;
      word_t lo;
   } hilo_t;

endpackage

// File: rtl/hilo_seq.sv
// hilo_seq: sequences an external multi-cycle multiplier and owns the
// architectural HI/LO registers.
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   start, op_a, op_b   : multiply request; operands sampled in the start cycle
//   mthi, mtlo, wdata   : direct HI/LO writes, honoured only while idle
//   mult_a, mult_b      : registered operands to the multiplier
//   mult_ctrl, mult_rst : multiplier enable and synchronous clear
//   mult_hi/lo, done    : multiplier result and (sticky) done flag
//   hi, lo              : architectural HI/LO
//   busy, done_pulse    : stall request, one-cycle completion flag
//   err                 : sticky timeout flag, cleared only by reset
module hilo_seq
   import hilo_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   input  logic              mthi,
   input  logic              mtlo,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] mult_a,
   output logic [DATA_W-1:0] mult_b,
   output logic              mult_ctrl,
   output logic              mult_rst,
   input  logic [DATA_W-1:0] mult_hi,
   input  logic [DATA_W-1:0] mult_lo,
   input  logic              mult_done,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo,
   output logic              busy,
   output logic              done_pulse,
   output logic              err
);

   state_e             state_q,      state_d;
   logic [CNT_W-1:0]   run_cnt_q,    run_cnt_d;
   word_t              mult_a_q,     mult_a_d;
   word_t              mult_b_q,     mult_b_d;
   hilo_t              hilo_q,       hilo_d;
   logic               mult_ctrl_q,  mult_ctrl_d;
   logic               mult_rst_q,   mult_rst_d;
   logic               busy_q,       busy_d;
   logic               done_pulse_q, done_pulse_d;
   logic               err_q,        err_d;

   // mult_done may be left over from the previous operation until the
   // multiplier has had MULT_LAT enabled cycles, so it is masked until then.
   logic               run_ripe;
   logic               run_expired;

   assign run_ripe    = (run_cnt_q >= CNT_W'(MULT_LAT));
   assign run_expired = (run_cnt_q == CNT_W'(TIMEOUT));

   // Next-state and next-output logic. Registered outputs are computed from
   // the next state, so each is valid in the same cycle as its state; the
   // HI/LO capture is loaded on the RUN->CAPT edge so the new value and
   // done_pulse are both visible during the CAPT cycle.
   always_comb begin
      state_d      = state_q;
      run_cnt_d    = run_cnt_q;
      mult_a_d     = mult_a_q;
      mult_b_d     = mult_b_q;
      hilo_d       = hilo_q;
      done_pulse_d = 1'b0;
      err_d        = err_q;

      case (state_q)
         IDLE: begin
            if (mthi) begin
               hilo_d.hi = wdata;
            end
            if (mtlo) begin
               hilo_d.lo = wdata;
            end
            if (start) begin
               mult_a_d  = op_a;
               mult_b_d  = op_b;
               run_cnt_d = '0;
               state_d   = CLR;
            end
         end

         CLR: begin
            run_cnt_d = '0;
            state_d   = RUN;
         end

         RUN: begin
            run_cnt_d = run_cnt_q + CNT_W'(1);
            if (run_ripe && mult_done) begin
               hilo_d.hi    = mult_hi;
               hilo_d.lo    = mult_lo;
               done_pulse_d = 1'b1;
               state_d      = CAPT;
            end else if (run_expired) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end

         CAPT: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      mult_ctrl_d = (state_d == RUN);
      mult_rst_d  = (state_d == CLR);
      busy_d      = (state_d != IDLE);
   end

   // State and output registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         run_cnt_q    <= '0;
         mult_a_q     <= '0;
         mult_b_q     <= '0;
         hilo_q       <= '0;
         mult_ctrl_q  <= 1'b0;
         mult_rst_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_pulse_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         run_cnt_q    <= run_cnt_d;
         mult_a_q     <= mult_a_d;
         mult_b_q     <= mult_b_d;
         hilo_q       <= hilo_d;
         mult_ctrl_q  <= mult_ctrl_d;
         mult_rst_q   <= mult_rst_d;
         busy_q       <= busy_d;
         done_pulse_q <= done_pulse_d;
         err_q        <= err_d;
      end
   end

   assign mult_a     = mult_a_q;
   assign mult_b     = mult_b_q;
   assign mult_ctrl  = mult_ctrl_q;
   // Multiplier clears together with this block while reset is low.
   assign mult_rst   = mult_rst_q | ~reset;
   assign hi         = hilo_q.hi;
   assign lo         = hilo_q.lo;
   assign busy       = busy_q;
   assign done_pulse = done_pulse_q;
   assign err        = err_q;

endmodule

// File: tb/tb_hilo_seq.sv
// tb_hilo_seq: scoreboard bench for hilo_seq with a behavioural multiplier
// stand-in and an architectural HI/LO reference model.
module tb_hilo_seq;
   import hilo_pkg::*;

   localparam int NOM_LAT   = 37; // start cycle -> cycle with new hi/lo and done_pulse
   localparam int BUSY_SPAN = 37; // busy cycles 1..37 (CLR, 35 RUN, CAPT)
   localparam int TMO_SPAN  = 65; // busy cycles 1..65 (CLR, 64 RUN) before abort

   localparam int M_NORM   = 0; // done after m_lat enabled cycles, cleared by mult_rst
   localparam int M_STICKY = 1; // like NORM but done/result survive mult_rst (stale)
   localparam int M_TIED1  = 2; // done held at 1
   localparam int M_TIED0  = 3; // done held at 0

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        mthi  = 1'b0;
   logic        mtlo  = 1'b0;
   logic [31:0] op_a  = '0;
   logic [31:0] op_b  = '0;
   logic [31:0] wdata = '0;
   logic [31:0] mult_a, mult_b, mult_hi, mult_lo, hi, lo;
   logic        mult_ctrl, mult_rst, mult_done, busy, done_pulse, err;

   hilo_seq dut (
      .clock(clock), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
      .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .mult_a(mult_a), .mult_b(mult_b),
      .mult_ctrl(mult_ctrl), .mult_rst(mult_rst), .mult_hi(mult_hi),
      .mult_lo(mult_lo), .mult_done(mult_done), .hi(hi), .lo(lo), .busy(busy),
      .done_pulse(done_pulse), .err(err)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
   endfunction

   // Multiplier stand-in
   int          m_mode = M_NORM;
   int          m_lat  = 34;
   int          m_cnt  = 0;
   logic        m_done = 1'b0;
   logic [63:0] m_prod = '0;
   assign mult_done = m_done;
   assign mult_hi   = m_prod[63:32];
   assign mult_lo   = m_prod[31:0];

   always @(posedge clock) begin
      if (m_mode == M_TIED1) begin
         m_done <= 1'b1;
         m_prod <= ref_prod(mult_a, mult_b);
      end else if (m_mode == M_TIED0) begin
         m_done <= 1'b0;
         m_cnt  <= 0;
      end else if (mult_rst) begin
         m_cnt <= 0;
         if (m_mode == M_NORM) m_done <= 1'b0;
      end else if (mult_ctrl) begin
         m_cnt <= m_cnt + 1;
         if (m_cnt + 1 == m_lat) begin
            m_done <= 1'b1;
            m_prod <= ref_prod(mult_a, mult_b);
         end
      end
   end

   // Architectural model and scoreboard
   logic [31:0] mdl_hi = '0;
   logic [31:0] mdl_lo = '0;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          start_cyc;
   } exp_t;
   exp_t sb_q[$];

   // Monitor: every done_pulse must match the oldest outstanding operation
   always @(negedge clock) begin
      exp_t e;
      if (reset === 1'b1 && done_pulse === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("spurious_done", 64'(done_pulse), 64'd0);
         end else begin
            e = sb_q.pop_front();
            check("cap_hi", 64'(hi), 64'(e.hi));
            check("cap_lo", 64'(lo), 64'(e.lo));
            check("cap_latency", 64'(cyc - e.start_cyc + 1), 64'(NOM_LAT));
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_idle(input int bound, output int waited);
      waited = 0;
      while (busy !== 1'b0 && waited < bound) begin
         tick();
         waited++;
      end
      if (busy !== 1'b0) check("idle_bound", 64'(busy), 64'd0);
   endtask

   // Issue a start (optionally with mthi/mtlo); returns in cycle 1
   task automatic do_start(input logic [31:0] a, input logic [31:0] b, input bit wh,
                           input bit wl, input logic [31:0] wd, input bit track);
      exp_t        e;
      logic [63:0] p;
      op_a = a; op_b = b; start = 1'b1; mthi = wh; mtlo = wl; wdata = wd;
      tick();
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      op_a = $urandom(); op_b = $urandom(); wdata = $urandom();
      if (wh) mdl_hi = wd;
      if (wl) mdl_lo = wd;
      check("start_hi", 64'(hi), 64'(mdl_hi));
      check("start_lo", 64'(lo), 64'(mdl_lo));
      check("opnd_a", 64'(mult_a), 64'(a));
      check("opnd_b", 64'(mult_b), 64'(b));
      check("busy_c1", 64'(busy), 64'd1);
      check("clr_rst", 64'(mult_rst), 64'd1);
      check("clr_ctrl", 64'(mult_ctrl), 64'd0);
      if (track) begin
         p = ref_prod(a, b);
         e.hi = p[63:32];
         e.lo = p[31:0];
         e.start_cyc = cyc;
         sb_q.push_back(e);
      end
   endtask

   task automatic finish_op(input logic [31:0] a, input logic [31:0] b, input int span);
      int          w;
      logic [63:0] p;
      wait_idle(200, w);
      p = ref_prod(a, b);
      mdl_hi = p[63:32];
      mdl_lo = p[31:0];
      check("busy_span", 64'(w), 64'(span));
      check("arch_hi", 64'(hi), 64'(mdl_hi));
      check("arch_lo", 64'(lo), 64'(mdl_lo));
      check("hold_a", 64'(mult_a), 64'(a));
      check("hold_b", 64'(mult_b), 64'(b));
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit wh,
                         input bit wl, input logic [31:0] wd);
      do_start(a, b, wh, wl, wd, 1'b1);
      finish_op(a, b, BUSY_SPAN);
   endtask

   task automatic do_write(input bit wh, input bit wl, input logic [31:0] wd);
      mthi = wh; mtlo = wl; wdata = wd;
      tick();
      mthi = 1'b0; mtlo = 1'b0;
      if (wh) mdl_hi = wd;
      if (wl) mdl_lo = wd;
      check("wr_hi", 64'(hi), 64'(mdl_hi));
      check("wr_lo", 64'(lo), 64'(mdl_lo));
      check("wr_busy", 64'(busy), 64'd0);
   endtask

   function automatic logic [31:0] pick_opnd();
      case ($urandom_range(4, 0))
         0:       return 32'h8000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h7FFF_FFFF;
         default: return $urandom();
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int          w;
      logic [31:0] a, b;

      // Reset values
      repeat (2) tick();
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_done", 64'(done_pulse), 64'd0);
      check("rst_ctrl", 64'(mult_ctrl), 64'd0);
      check("rst_mrst", 64'(mult_rst), 64'd1);
      reset = 1'b1;
      tick();
      check("rel_mrst", 64'(mult_rst), 64'd0);
      check("rel_busy", 64'(busy), 64'd0);

      // 7 * -3 with busy sampled in cycles 1 and 36
      m_mode = M_NORM; m_lat = 34;
      do_start(32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0, '0, 1'b1);
      repeat (35) tick();
      check("busy_c36", 64'(busy), 64'd1);
      check("run_ctrl", 64'(mult_ctrl), 64'd1);
      finish_op(32'd7, 32'hFFFF_FFFD, BUSY_SPAN - 35);
      check("neg_hi", 64'(hi), 64'hFFFF_FFFF);
      check("neg_lo", 64'(lo), 64'hFFFF_FFEB);

      // Back-to-back operations with a stale done from the first
      m_mode = M_STICKY; m_lat = 34;
      run_op(32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, '0);
      check("b2b1_hi", 64'(hi), 64'd1);
      check("b2b1_lo", 64'(lo), 64'd0);
      run_op(32'd7, 32'd6, 1'b0, 1'b0, '0);
      check("b2b2_hi", 64'(hi), 64'd0);
      check("b2b2_lo", 64'(lo), 64'h2A);

      // done held high: capture still waits for the full RUN window
      m_mode = M_TIED1;
      run_op($urandom(), $urandom(), 1'b0, 1'b0, '0);

      // Idle writes, then writes and start while busy are ignored
      m_mode = M_NORM; m_lat = $urandom_range(34, 1);
      do_write(1'b1, 1'b0, 32'hDEAD_BEEF);
      do_write(1'b0, 1'b1, 32'h1234_5678);
      a = $urandom(); b = $urandom();
      do_start(a, b, 1'b0, 1'b0, '0, 1'b1);
      repeat (4) tick();
      mthi = 1'b1; mtlo = 1'b1; wdata = $urandom(); start = 1'b1;
      op_a = ~a; op_b = ~b;
      tick();
      mthi = 1'b0; mtlo = 1'b0; start = 1'b0;
      check("busy_wr_hi", 64'(hi), 64'hDEAD_BEEF);
      check("busy_wr_lo", 64'(lo), 64'h1234_5678);
      check("busy_start_a", 64'(mult_a), 64'(a));
      finish_op(a, b, BUSY_SPAN - 5);

      // Start together with both writes: write lands, capture overwrites
      run_op(pick_opnd(), pick_opnd(), 1'b1, 1'b1, $urandom());

      // Timeout: no done ever arrives
      m_mode = M_TIED0;
      do_write(1'b1, 1'b1, 32'hA5A5_0F0F);
      do_start($urandom(), $urandom(), 1'b0, 1'b0, '0, 1'b0);
      check("tmo_err_pre", 64'(err), 64'd0);
      wait_idle(200, w);
      check("tmo_span", 64'(w), 64'(TMO_SPAN));
      check("tmo_err", 64'(err), 64'd1);
      check("tmo_hi", 64'(hi), 64'(mdl_hi));
      check("tmo_lo", 64'(lo), 64'(mdl_lo));

      // err stays set across a normal operation
      m_mode = M_NORM; m_lat = 34;
      run_op(pick_opnd(), pick_opnd(), 1'b0, 1'b0, '0);
      check("err_sticky", 64'(err), 64'd1);

      // Reset in RUN cycle 10 aborts with no capture
      a = $urandom(); b = $urandom();
      do_start(a, b, 1'b0, 1'b0, '0, 1'b0);
      repeat (11) tick();
      check("pre_rst_busy", 64'(busy), 64'd1);
      reset = 1'b0;
      #1;
      mdl_hi = '0; mdl_lo = '0;
      check("arst_hi", 64'(hi), 64'd0);
      check("arst_lo", 64'(lo), 64'd0);
      check("arst_a", 64'(mult_a), 64'd0);
      check("arst_b", 64'(mult_b), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_err", 64'(err), 64'd0);
      check("arst_done", 64'(done_pulse), 64'd0);
      check("arst_ctrl", 64'(mult_ctrl), 64'd0);
      check("arst_mrst", 64'(mult_rst), 64'd1);
      repeat (3) tick();
      check("arst_hold_mrst", 64'(mult_rst), 64'd1);
      reset = 1'b1;
      repeat (45) tick();
      check("post_rst_busy", 64'(busy), 64'd0);
      check("post_rst_hi", 64'(hi), 64'd0);
      run_op(pick_opnd(), pick_opnd(), 1'b0, 1'b0, '0);

      // Randomised operations
      for (int i = 0; i < 16; i++) begin
         m_mode = ($urandom_range(2, 0) == 0) ? M_STICKY : M_NORM;
         m_lat  = $urandom_range(34, 1);
         if ($urandom_range(1, 0) == 1)
            do_write(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), $urandom());
         run_op(pick_opnd(), pick_opnd(), 1'($urandom_range(1, 0)),
                1'($urandom_range(1, 0)), $urandom());
      end

      repeat (3) tick();
      check("sb_drain", 64'(sb_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
